// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: ALU op codes and the default-width result-buffer entry.
// The cdb flags field exists only when ADD_EXEC_FLAGS_EN is defined.
package tomasulo_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_AND = 4'b0010;
  localparam logic [3:0] FUNC_OR  = 4'b0011;
  localparam logic [3:0] FUNC_XOR = 4'b0100;
  localparam logic [3:0] FUNC_SLT = 4'b0101;

  localparam int unsigned PKG_DATA_W = 8;
  localparam int unsigned PKG_ROB_W  = 3;
  localparam int unsigned PKG_REG_W  = 4;

  typedef struct packed {
    logic [PKG_DATA_W-1:0] data;
    logic [PKG_ROB_W-1:0]  rob;
    logic [PKG_REG_W-1:0]  rd;
    logic                  illegal;
`ifdef ADD_EXEC_FLAGS_EN
    logic [1:0]            flags;
`endif
  } res_entry_t;

endpackage

// File: rtl/exec_result_fifo.sv
// In-order result buffer, DEPTH entries; pushed entry is visible at the head one cycle later.
// No internal backpressure: the producer must never push when full (credit scheme guarantees it).
module exec_result_fifo
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = res_entry_t,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  entry_t           push_dat,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output entry_t           head_dat
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr_q] <= push_dat;
  end

  // Head reads as zero when empty so the CDB payload is clean after reset/flush.
  assign head_dat = (cnt_q == '0) ? entry_t'(0) : mem[rd_ptr_q];
  assign count    = cnt_q;

endmodule

// File: rtl/add_exec_pipe.sv
// Pipelined add/sub/logic unit: accept->cdb_valid in LAT cycles, results buffered in order for the CDB.
// Credit-based issue_ready (never drops a result); ADD_EXEC_FLAGS_EN adds carry/overflow on cdb_flags.
module add_exec_pipe
  import tomasulo_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ROB_W      = 3,
  parameter int unsigned RS_W       = 3,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned LAT        = 2,
  parameter int unsigned OBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_func,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic [RS_W-1:0]   issue_rs,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              rs_free_valid,
  output logic [RS_W-1:0]   rs_free_idx,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [DATA_W-1:0] cdb_data,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic [REG_W-1:0]  cdb_rd,
`ifdef ADD_EXEC_FLAGS_EN
  output logic [1:0]        cdb_flags,
`endif
  output logic              cdb_illegal
);

  localparam int unsigned CRD_W = $clog2(OBUF_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
    logic [REG_W-1:0]  rd;
    logic              illegal;
`ifdef ADD_EXEC_FLAGS_EN
    logic [1:0]        flags;
`endif
  } entry_t;

  logic             accept, pop;
  logic [CRD_W-1:0] credits_q, credits_d;
  logic             rs_free_vld_q, rs_free_vld_d;
  logic [RS_W-1:0]  rs_free_idx_q, rs_free_idx_d;
  entry_t           new_ent, push_ent, head_ent;
  logic             push_vld;
  logic [CRD_W-1:0] obuf_cnt;

  assign issue_ready = (credits_q != '0) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign cdb_valid   = (obuf_cnt != '0);
  assign pop         = cdb_valid && cdb_ready && !flush;

`ifdef ADD_EXEC_FLAGS_EN
  logic [DATA_W:0] sum_w, dif_w;
  logic [1:0]      flg;
  always_comb begin
    sum_w = {1'b0, issue_a} + {1'b0, issue_b};
    dif_w = {1'b0, issue_a} - {1'b0, issue_b};
    flg   = '0;
    case (issue_func)
      FUNC_ADD: flg = {sum_w[DATA_W], (issue_a[DATA_W-1] == issue_b[DATA_W-1]) &&
                                      (sum_w[DATA_W-1] != issue_a[DATA_W-1])};
      // Carry on SUB is the unsigned borrow.
      FUNC_SUB: flg = {dif_w[DATA_W], (issue_a[DATA_W-1] != issue_b[DATA_W-1]) &&
                                      (dif_w[DATA_W-1] != issue_a[DATA_W-1])};
      default:  flg = '0;
    endcase
  end
`endif

  always_comb begin
    new_ent     = '0;
    new_ent.rob = issue_rob;
    new_ent.rd  = issue_rd;
    case (issue_func)
      FUNC_ADD: new_ent.data = issue_a + issue_b;
      FUNC_SUB: new_ent.data = issue_a - issue_b;
      FUNC_AND: new_ent.data = issue_a & issue_b;
      FUNC_OR:  new_ent.data = issue_a | issue_b;
      FUNC_XOR: new_ent.data = issue_a ^ issue_b;
      FUNC_SLT: new_ent.data = DATA_W'($signed(issue_a) < $signed(issue_b));
      default:  new_ent.illegal = 1'b1;
    endcase
`ifdef ADD_EXEC_FLAGS_EN
    new_ent.flags = flg;
`endif
  end

  // LAT-1 stage registers; the result buffer register supplies the final cycle.
  generate
    if (LAT == 1) begin : g_direct
      assign push_vld = accept;
      assign push_ent = new_ent;
    end else begin : g_stages
      localparam int unsigned NSTG = LAT - 1;
      logic [NSTG-1:0] stg_vld_q, stg_vld_d;
      entry_t          stg_ent_q [NSTG];
      entry_t          stg_ent_d [NSTG];

      always_comb begin
        stg_vld_d[0] = accept;
        stg_ent_d[0] = new_ent;
        for (int i = 1; i < NSTG; i++) begin
          stg_vld_d[i] = stg_vld_q[i-1];
          stg_ent_d[i] = stg_ent_q[i-1];
        end
        if (flush) stg_vld_d = '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_vld_q <= '0;
          for (int i = 0; i < NSTG; i++) stg_ent_q[i] <= '0;
        end else begin
          stg_vld_q <= stg_vld_d;
          stg_ent_q <= stg_ent_d;
        end
      end

      assign push_vld = stg_vld_q[NSTG-1];
      assign push_ent = stg_ent_q[NSTG-1];
    end
  endgenerate

  exec_result_fifo #(
    .DEPTH   (OBUF_DEPTH),
    .entry_t (entry_t)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push_vld),
    .push_dat (push_ent),
    .pop      (pop),
    .count    (obuf_cnt),
    .head_dat (head_ent)
  );

  always_comb begin
    credits_d     = flush ? CRD_W'(OBUF_DEPTH) : credits_q - CRD_W'(accept) + CRD_W'(pop);
    rs_free_vld_d = accept;
    rs_free_idx_d = accept ? issue_rs : rs_free_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q     <= CRD_W'(OBUF_DEPTH);
      rs_free_vld_q <= 1'b0;
      rs_free_idx_q <= '0;
    end else begin
      credits_q     <= credits_d;
      rs_free_vld_q <= rs_free_vld_d;
      rs_free_idx_q <= rs_free_idx_d;
    end
  end

  assign rs_free_valid = rs_free_vld_q;
  assign rs_free_idx   = rs_free_idx_q;
  assign cdb_data      = head_ent.data;
  assign cdb_rob       = head_ent.rob;
  assign cdb_rd        = head_ent.rd;
  assign cdb_illegal   = head_ent.illegal;
`ifdef ADD_EXEC_FLAGS_EN
  assign cdb_flags     = head_ent.flags;
`endif

endmodule

// File: tb/tb_add_exec_pipe.sv
// Randomized bench for add_exec_pipe with an in-order queue model of results, credits and RS frees.
module tb_add_exec_pipe;

  localparam int DATA_W = 8, ROB_W = 3, RS_W = 3, REG_W = 4, LAT = 2, OBUF_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n, flush, issue_valid, cdb_ready;
  logic              issue_ready, rs_free_valid, cdb_valid, cdb_illegal;
  logic [3:0]        issue_func;
  logic [DATA_W-1:0] issue_a, issue_b, cdb_data;
  logic [ROB_W-1:0]  issue_rob, cdb_rob;
  logic [RS_W-1:0]   issue_rs, rs_free_idx;
  logic [REG_W-1:0]  issue_rd, cdb_rd;
`ifdef ADD_EXEC_FLAGS_EN
  logic [1:0]        cdb_flags;
`endif

  add_exec_pipe #(
    .DATA_W(DATA_W), .ROB_W(ROB_W), .RS_W(RS_W), .REG_W(REG_W),
    .LAT(LAT), .OBUF_DEPTH(OBUF_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rob(issue_rob), .issue_rs(issue_rs),
    .issue_rd(issue_rd), .rs_free_valid(rs_free_valid), .rs_free_idx(rs_free_idx),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data), .cdb_rob(cdb_rob),
    .cdb_rd(cdb_rd),
`ifdef ADD_EXEC_FLAGS_EN
    .cdb_flags(cdb_flags),
`endif
    .cdb_illegal(cdb_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data; int rob; int rd; int ill; int flags; int due;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, outst = 0, n_rsf = 0;
  bit   mon_en = 0, rsf_pend = 0;
  int   rsf_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference result computed from the op definitions with integer arithmetic.
  function automatic exp_t model(int f, int a, int b, int rob, int rd, int due);
    exp_t e;
    int m  = 1 << DATA_W;
    int h  = m / 2;
    int sa = (a >= h) ? a - m : a;
    int sb = (b >= h) ? b - m : b;
    int s;
    e.rob = rob; e.rd = rd; e.due = due; e.ill = 0; e.flags = 0; e.data = 0;
    case (f)
      0: begin s = a + b; e.data = s % m;
               e.flags = ((s >= m) ? 2 : 0) + (((sa + sb) >= h || (sa + sb) < -h) ? 1 : 0); end
      1: begin e.data = (a - b + m) % m;
               e.flags = ((a < b) ? 2 : 0) + (((sa - sb) >= h || (sa - sb) < -h) ? 1 : 0); end
      2: e.data = a & b;
      3: e.data = a | b;
      4: e.data = a ^ b;
      5: e.data = (sa < sb) ? 1 : 0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_rdy, exp_vld, acc, pop;
      exp_t e;
      exp_rdy = (outst < OBUF_DEPTH) && !flush;
      exp_vld = (q.size() > 0) && (q[0].due <= cyc);
      check("issue_ready", issue_ready, exp_rdy);
      check("rs_free_valid", rs_free_valid, rsf_pend);
      if (rsf_pend) check("rs_free_idx", rs_free_idx, rsf_idx);
      check("cdb_valid", cdb_valid, exp_vld);
      if (exp_vld) begin
        check("cdb_data", cdb_data, q[0].data);
        check("cdb_rob", cdb_rob, q[0].rob);
        check("cdb_rd", cdb_rd, q[0].rd);
        check("cdb_illegal", cdb_illegal, q[0].ill);
`ifdef ADD_EXEC_FLAGS_EN
        check("cdb_flags", cdb_flags, q[0].flags);
`endif
      end
      if (rs_free_valid === 1'b1) n_rsf++;
      acc = issue_valid && exp_rdy;
      pop = exp_vld && cdb_ready && !flush;
      if (flush) begin
        q.delete();
        outst    = 0;
        rsf_pend = 0;
      end else begin
        if (pop) begin void'(q.pop_front()); outst--; end
        if (acc) begin
          e = model(int'(issue_func), int'(issue_a), int'(issue_b),
                    int'(issue_rob), int'(issue_rd), cyc + LAT);
          q.push_back(e);
          outst++;
        end
        rsf_pend = acc;
        rsf_idx  = int'(issue_rs);
      end
    end
  end

  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] rob, input logic [2:0] rs, input logic [3:0] rd);
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_func = f; issue_a = a; issue_b = b;
    issue_rob = rob; issue_rs = rs; issue_rd = rd; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      issue_valid = 1'b0; flush = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; cdb_ready = 1'b1;
    issue_func = '0; issue_a = '0; issue_b = '0; issue_rob = '0; issue_rs = '0; issue_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_rs_free_valid", rs_free_valid, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_illegal", cdb_illegal, 0);
    rst_n = 1'b1;
    #1 mon_en = 1;
    @(negedge clk);
    check("rdy_after_rst", issue_ready, 1);

    // First ADD: rs_free at T+1, result at T+2.
    issue(4'h0, 8'h0F, 8'h01, 3'd3, 3'd2, 4'd5);
    idle(1);
    @(negedge clk);
    check("add_rsfree_t1", rs_free_valid, 1);
    check("add_rsidx_t1", rs_free_idx, 2);
    check("add_noval_t1", cdb_valid, 0);
    @(negedge clk);
    check("add_val_t2", cdb_valid, 1);
    check("add_data", cdb_data, 8'h10);
    check("add_rob", cdb_rob, 3);
    check("add_rd", cdb_rd, 5);
    idle(3);

    issue(4'h1, 8'h00, 8'h01, 3'd1, 3'd1, 4'd1);
    issue(4'h5, 8'h80, 8'h01, 3'd2, 3'd3, 4'd2);
    issue(4'h0, 8'hFF, 8'h01, 3'd4, 3'd4, 4'd3);
    issue(4'hF, 8'h12, 8'h34, 3'd5, 3'd5, 4'd4);
    issue(4'h4, 8'hA5, 8'h5A, 3'd6, 3'd6, 4'd6);
    idle(6);

    // Backpressure: only OBUF_DEPTH ops accepted while the CDB is blocked.
    cdb_ready = 1'b0;
    base = n_rsf;
    for (int i = 0; i < 4; i++) issue(4'h0, 8'(i), 8'(i + 1), 3'(i), 3'(i), 4'(i));
    idle(3);
    @(negedge clk);
    check("bp_ready_low", issue_ready, 0);
    check("bp_accepted", n_rsf - base, 2);
    check("bp_cdb_valid", cdb_valid, 1);
    cdb_ready = 1'b1;
    idle(4);
    @(negedge clk);
    check("bp_ready_back", issue_ready, 1);
    check("bp_drained", cdb_valid, 0);

    // Flush with ops in flight and buffered.
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(4'h2, 8'hF0, 8'h3C, 3'(i), 3'(i + 4), 4'(i));
    @(posedge clk); #1; issue_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("fl_cdb_valid", cdb_valid, 0);
    check("fl_rs_free", rs_free_valid, 0);
    idle(3);
    @(negedge clk);
    check("fl_stay_empty", cdb_valid, 0);
    base = n_rsf;
    for (int i = 0; i < OBUF_DEPTH; i++) issue(4'h3, 8'h01, 8'h80, 3'(i), 3'(i), 4'(i));
    idle(4);
    @(negedge clk);
    check("fl_credits", n_rsf - base, OBUF_DEPTH);
    cdb_ready = 1'b1;
    idle(3);
    issue(4'h0, 8'h21, 8'h21, 3'd7, 3'd7, 4'd15);
    idle(5);

    // Randomized traffic with occasional flushes and illegal codes.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      issue_valid = ($urandom_range(0, 9) < 7);
      issue_func  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      issue_a     = 8'($urandom);
      issue_b     = 8'($urandom);
      issue_rob   = 3'($urandom);
      issue_rs    = 3'($urandom);
      issue_rd    = 4'($urandom);
      cdb_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 39) == 0);
    end
    cdb_ready = 1'b1;
    idle(10);

    // Asynchronous reset while a result is waiting.
    cdb_ready = 1'b0;
    issue(4'h0, 8'h05, 8'h06, 3'd1, 3'd1, 4'd1);
    idle(4);
    @(negedge clk);
    check("ar_pre_valid", cdb_valid, 1);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_cdb_valid", cdb_valid, 0);
    check("ar_cdb_data", cdb_data, 0);
    check("ar_rs_free", rs_free_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
